mem_requester: RTL and testbench
================================

Name: mem_requester

Overview:
- Initiator for the memory enable/ready interface; drives the memory-side ports that a memory responder serves.
- Accepts one read or write at a time from a client over a valid/ready request channel.
- Holds the memory enable until the matching ready pulse arrives.
- Returns the result on a valid/ready response channel, then enforces an idle gap so the responder's delay counter clears before the next transaction.

Parameters:
- MADDR_WIDTH, `DEFAULT_MADDR_WIDTH: memory address width in bits.
- MDATA_WIDTH, `DEFAULT_MDATA_WIDTH: memory data width in bits.
- GAP_CYCLES, 1: minimum number of edges with both enables low between transactions; must be at least 1.
- TIMEOUT_CYCLES, 64: watchdog limit in BUSY; used only with MEM_REQ_TIMEOUT_EN.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  1  client request present.
- req_ready  out  1  requester can accept a request.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  MADDR_WIDTH  request address.
- req_wdata  in  MDATA_WIDTH  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  client accepts the response.
- rsp_rdata  out  MDATA_WIDTH  read data; 0 for writes.
- rsp_error  out  1  transaction timed out.
- mem_read_enable  out  1  read request to memory.
- mem_write_enable  out  1  write request to memory.
- mem_read_ready  in  1  read-complete pulse from memory.
- mem_write_ready  in  1  write-complete pulse from memory.
- mem_addr  out  MADDR_WIDTH  memory address.
- mem_write_data  out  MDATA_WIDTH  memory write data.
- mem_read_data  in  MDATA_WIDTH  memory read data.

Behaviour:
- Reset: reset==0 at a rising edge forces the following, all registered:
  - state IDLE;
  - mem_read_enable = mem_write_enable = 0;
  - mem_addr = 0, mem_write_data = 0;
  - rsp_valid = 0, rsp_rdata = 0, rsp_error = 0;
  - gap and watchdog counters = 0.
- req_ready = (state==IDLE) && reset; combinational.
- State IDLE:
  - Accept on an edge with req_valid && req_ready.
  - Latch req_addr into mem_addr and req_wdata into mem_write_data.
  - Assert exactly one enable per req_write; go BUSY.
  - The enable is visible the cycle after the accepting edge.
- State BUSY:
  - mem_addr, mem_write_data and the enable are held stable.
  - An edge sampling the matching ready high (mem_write_ready for a write, mem_read_ready for a read) does the following:
    - deasserts the enable;
    - reads: rsp_rdata <= mem_read_data; writes: rsp_rdata <= 0;
    - rsp_error <= 0, rsp_valid <= 1; go RESP.
  - The non-matching ready is ignored.
- State RESP:
  - rsp_valid, rsp_rdata and rsp_error are held until an edge with rsp_ready==1.
  - At that edge rsp_valid <= 0; go GAP with gap counter = 0.
- State GAP:
  - Both enables stay low.
  - The counter increments each edge; at GAP_CYCLES-1 go IDLE.
  - Memory sees at least GAP_CYCLES edges with enables low, so its delay counter restarts.
- Invariants:
  - Both enables are never high together.
  - The enables are low in every state except BUSY.
- Memory ready pulses in IDLE, RESP or GAP (including a duplicate completion on the deassert edge) are ignored and produce no response.
- Reset mid-transaction: the enables drop at that edge, the transaction is discarded and no response is issued.
- req_* values are sampled only on the accepting edge.

Optional Feature:
- MEM_REQ_TIMEOUT_EN defined:
  - A watchdog counter clears on entry to BUSY and increments each BUSY edge.
  - When it reaches TIMEOUT_CYCLES with no matching ready: the enable is deasserted, rsp_rdata <= 0, rsp_error <= 1, rsp_valid <= 1; go RESP. The GAP state follows as normal.
  - If a matching ready and the limit coincide on the same edge, the ready wins (rsp_error = 0).
- MEM_REQ_TIMEOUT_EN undefined:
  - No watchdog logic; rsp_error is tied 0.
  - BUSY waits indefinitely.

Test Plan:
- Reset held low for 3 edges, with req_valid=1 and mem_*_ready=1 -> all outputs 0 and req_ready=0; no enable asserted.
- Write addr 0x10, data 0xDEADBEEF, to a memory model with DELAY=10, rsp_ready=1 -> mem_write_enable high from edge 1 to edge 12; rsp_valid high after edge 12 with rsp_rdata=0 and rsp_error=0.
- Read addr 0x10 after that write, same model -> rsp_rdata=0xDEADBEEF and mem_read_enable never overlaps mem_write_enable; then two back-to-back requests with req_valid held -> at least GAP_CYCLES enable-low edges between them, and the second completes with the same latency as the first.
- rsp_ready held 0 for 5 cycles after a read completes -> rsp_valid and rsp_rdata stable, req_ready=0, enables low, memory ready pulses ignored.
- Reset asserted while in BUSY -> enable 0 next edge, no rsp_valid; a new request after reset completes normally.
- With MEM_REQ_TIMEOUT_EN and TIMEOUT_CYCLES=8, memory never responds -> rsp_valid with rsp_error=1 and rsp_rdata=0 after 8 BUSY edges; without the macro, rsp_valid stays 0 for 1000 cycles.

Source files
------------

// File: rtl/mem_requester_if.sv
// Bundled request, response and memory-side signals of mem_requester.
// The requester side uses modport master; the client/memory side uses modport slave.

`ifndef DEFAULT_MADDR_WIDTH
`define DEFAULT_MADDR_WIDTH 32
`endif
`ifndef DEFAULT_MDATA_WIDTH
`define DEFAULT_MDATA_WIDTH 32
`endif

interface mem_requester_if #(
    parameter int MADDR_WIDTH = `DEFAULT_MADDR_WIDTH,
    parameter int MDATA_WIDTH = `DEFAULT_MDATA_WIDTH
);
    // client request channel
    logic                   req_valid;
    logic                   req_ready;
    logic                   req_write;
    logic [MADDR_WIDTH-1:0] req_addr;
    logic [MDATA_WIDTH-1:0] req_wdata;

    // client response channel
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [MDATA_WIDTH-1:0] rsp_rdata;
    logic                   rsp_error;

    // memory enable/ready channel
    logic                   mem_read_enable;
    logic                   mem_write_enable;
    logic                   mem_read_ready;
    logic                   mem_write_ready;
    logic [MADDR_WIDTH-1:0] mem_addr;
    logic [MDATA_WIDTH-1:0] mem_write_data;
    logic [MDATA_WIDTH-1:0] mem_read_data;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_error,
        input  rsp_ready,
        output mem_read_enable, mem_write_enable, mem_addr, mem_write_data,
        input  mem_read_ready, mem_write_ready, mem_read_data
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_error,
        output rsp_ready,
        input  mem_read_enable, mem_write_enable, mem_addr, mem_write_data,
        output mem_read_ready, mem_write_ready, mem_read_data
    );
endinterface

// File: rtl/mem_requester.sv
// mem_requester: single-outstanding initiator for the memory enable/ready
// interface. A client request is latched, one enable is held until the
// matching ready pulse, the result is offered on the response channel, and an
// idle gap of GAP_CYCLES edges (GAP_CYCLES >= 1) follows so the responder's
// delay counter clears before the next transaction.
// Optional feature: define MEM_REQ_TIMEOUT_EN to add a BUSY watchdog that
// completes the transaction with rsp_error=1 after TIMEOUT_CYCLES edges.

`ifndef DEFAULT_MADDR_WIDTH
`define DEFAULT_MADDR_WIDTH 32
`endif
`ifndef DEFAULT_MDATA_WIDTH
`define DEFAULT_MDATA_WIDTH 32
`endif

module mem_requester #(
    parameter int MADDR_WIDTH    = `DEFAULT_MADDR_WIDTH,
    parameter int MDATA_WIDTH    = `DEFAULT_MDATA_WIDTH,
    parameter int GAP_CYCLES     = 1,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             clock,
    input  logic             reset,
    mem_requester_if.master  bus
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP,
        GAP
    } state_t;

    state_t                 state_q, state_d;
    logic                   rd_en_q, rd_en_d;
    logic                   wr_en_q, wr_en_d;
    logic [MADDR_WIDTH-1:0] addr_q, addr_d;
    logic [MDATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [MDATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [GAP_W-1:0]       gap_q, gap_d;
    logic                   req_ready_int;
    logic                   accept;
    logic                   mem_done;

`ifdef MEM_REQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic                   err_q, err_d;
    logic [WD_W-1:0]        wdog_q, wdog_d;
`endif

    assign req_ready_int = (state_q == IDLE) && reset;
    assign accept        = bus.req_valid && req_ready_int;

    // Only the ready that matches the active enable counts as completion.
    assign mem_done = (wr_en_q && bus.mem_write_ready) ||
                      (rd_en_q && bus.mem_read_ready);

    assign bus.req_ready        = req_ready_int;
    assign bus.mem_read_enable  = rd_en_q;
    assign bus.mem_write_enable = wr_en_q;
    assign bus.mem_addr         = addr_q;
    assign bus.mem_write_data   = wdata_q;
    assign bus.rsp_valid        = rsp_valid_q;
    assign bus.rsp_rdata        = rdata_q;
`ifdef MEM_REQ_TIMEOUT_EN
    assign bus.rsp_error        = err_q;
`else
    assign bus.rsp_error        = 1'b0;
`endif

    // Next-state and next-output logic for the transaction FSM.
    always_comb begin
        state_d     = state_q;
        rd_en_d     = rd_en_q;
        wr_en_d     = wr_en_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = rsp_valid_q;
        rdata_d     = rdata_q;
        gap_d       = gap_q;
`ifdef MEM_REQ_TIMEOUT_EN
        err_d       = err_q;
        wdog_d      = wdog_q;
`endif

        case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    wr_en_d = bus.req_write;
                    rd_en_d = !bus.req_write;
`ifdef MEM_REQ_TIMEOUT_EN
                    wdog_d  = '0;
`endif
                    state_d = BUSY;
                end
            end

            BUSY: begin
                if (mem_done) begin
                    rd_en_d     = 1'b0;
                    wr_en_d     = 1'b0;
                    rdata_d     = rd_en_q ? bus.mem_read_data : '0;
                    rsp_valid_d = 1'b1;
`ifdef MEM_REQ_TIMEOUT_EN
                    err_d       = 1'b0;
`endif
                    state_d     = RESP;
                end
`ifdef MEM_REQ_TIMEOUT_EN
                // A coincident ready takes priority over the watchdog limit.
                else if (wdog_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    rd_en_d     = 1'b0;
                    wr_en_d     = 1'b0;
                    rdata_d     = '0;
                    rsp_valid_d = 1'b1;
                    err_d       = 1'b1;
                    wdog_d      = WD_W'(TIMEOUT_CYCLES);
                    state_d     = RESP;
                end
                else begin
                    wdog_d = wdog_q + WD_W'(1);
                end
`endif
            end

            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    gap_d       = '0;
                    state_d     = GAP;
                end
            end

            GAP: begin
                rd_en_d = 1'b0;
                wr_en_d = 1'b0;
                if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end

            default: begin
                rd_en_d = 1'b0;
                wr_en_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= IDLE;
            rd_en_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            gap_q       <= '0;
`ifdef MEM_REQ_TIMEOUT_EN
            err_q       <= 1'b0;
            wdog_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            rd_en_q     <= rd_en_d;
            wr_en_q     <= wr_en_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            gap_q       <= gap_d;
`ifdef MEM_REQ_TIMEOUT_EN
            err_q       <= err_d;
            wdog_q      <= wdog_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_requester.sv
// Directed testbench for mem_requester with a simple delayed-ready memory model.
// Build with or without MEM_REQ_TIMEOUT_EN; the timeout section adapts.
`timescale 1ns/1ps

module tb_mem_requester;

    localparam int AW        = 16;
    localparam int DW        = 32;
    localparam int GAP       = 2;
    localparam int TMO       = 8;
    localparam int MEM_DELAY = 10;

    logic clock = 1'b0;
    logic reset = 1'b0;

    int tests_run = 0;
    int failed    = 0;
    int overlap   = 0;

    mem_requester_if #(.MADDR_WIDTH(AW), .MDATA_WIDTH(DW)) bus ();

    mem_requester #(
        .MADDR_WIDTH   (AW),
        .MDATA_WIDTH   (DW),
        .GAP_CYCLES    (GAP),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    // Memory model: ready pulses after MEM_DELAY edges of a held enable.
    logic          mem_auto = 1'b1;
    logic          force_rd = 1'b0;
    logic          force_wr = 1'b0;
    logic          m_rdy_rd = 1'b0;
    logic          m_rdy_wr = 1'b0;
    logic [DW-1:0] m_rdata  = '0;
    int            m_cnt    = 0;
    logic [DW-1:0] mem [0:255];

    assign bus.mem_read_ready  = m_rdy_rd | force_rd;
    assign bus.mem_write_ready = m_rdy_wr | force_wr;
    assign bus.mem_read_data   = m_rdata;

    always @(posedge clock) begin
        if (m_rdy_rd || m_rdy_wr) begin
            m_rdy_rd <= 1'b0;
            m_rdy_wr <= 1'b0;
            m_cnt    <= 0;
        end else if (mem_auto && (bus.mem_read_enable || bus.mem_write_enable)) begin
            if (m_cnt == MEM_DELAY - 1) begin
                m_cnt <= 0;
                if (bus.mem_write_enable) begin
                    mem[bus.mem_addr[7:0]] <= bus.mem_write_data;
                    m_rdy_wr <= 1'b1;
                end else begin
                    m_rdata  <= mem[bus.mem_addr[7:0]];
                    m_rdy_rd <= 1'b1;
                end
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end else begin
            m_cnt <= 0;
        end
    end

    always @(negedge clock) begin
        if (bus.mem_read_enable && bus.mem_write_enable) overlap++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one request at a negedge in IDLE; returns at the negedge after acceptance.
    task automatic issue(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = data;
        bus.req_valid = 1'b1;
        @(negedge clock);
        bus.req_valid = 1'b0;
    endtask

    // Count negedges the selected enable stays high; ends at the first low one.
    task automatic wait_done(input logic wr, output int hi);
        hi = 0;
        while ((wr ? bus.mem_write_enable : bus.mem_read_enable) && hi < 200) begin
            hi++;
            @(negedge clock);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (!bus.req_ready && n < 50) begin
            n++;
            @(negedge clock);
        end
        check(tag, {63'd0, bus.req_ready}, 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int hi, lo, hi2, seen;

        for (int i = 0; i < 256; i++) mem[i] = '0;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 16'h0055;
        bus.req_wdata = 32'hFFFF_FFFF;
        bus.rsp_ready = 1'b1;
        force_rd      = 1'b1;
        force_wr      = 1'b1;

        // Reset held low with request and readies active.
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("rst_req_ready", {63'd0, bus.req_ready}, 64'd0);
            check("rst_en", {62'd0, bus.mem_read_enable, bus.mem_write_enable}, 64'd0);
            check("rst_rsp", {31'd0, bus.rsp_valid, bus.rsp_error, bus.rsp_rdata}, 64'd0);
            check("rst_mem", {bus.mem_addr, bus.mem_write_data}, 64'd0);
        end
        bus.req_valid = 1'b0;
        force_rd      = 1'b0;
        force_wr      = 1'b0;
        reset         = 1'b1;
        @(negedge clock);
        check("idle_req_ready", {63'd0, bus.req_ready}, 64'd1);

        // Write 0xDEADBEEF to 0x10.
        issue(1'b1, 16'h0010, 32'hDEAD_BEEF);
        check("wr_addr", {48'd0, bus.mem_addr}, 64'h10);
        check("wr_data", {32'd0, bus.mem_write_data}, 64'hDEAD_BEEF);
        check("wr_rd_en_low", {63'd0, bus.mem_read_enable}, 64'd0);
        wait_done(1'b1, hi);
        check("wr_en_cycles", hi, 11);
        check("wr_rsp_valid", {63'd0, bus.rsp_valid}, 64'd1);
        check("wr_rsp_rdata", {32'd0, bus.rsp_rdata}, 64'd0);
        check("wr_rsp_error", {63'd0, bus.rsp_error}, 64'd0);
        @(negedge clock);
        check("wr_rsp_drop", {63'd0, bus.rsp_valid}, 64'd0);
        wait_idle("wr_idle");

        // Read back 0x10.
        issue(1'b0, 16'h0010, 32'h0);
        wait_done(1'b0, hi);
        check("rd_en_cycles", hi, 11);
        check("rd_rsp_valid", {63'd0, bus.rsp_valid}, 64'd1);
        check("rd_rsp_rdata", {32'd0, bus.rsp_rdata}, 64'hDEAD_BEEF);
        wait_idle("rd_idle");

        // Back-to-back reads with req_valid held: 1 RESP + 2 GAP + 1 IDLE low edges.
        bus.req_write = 1'b0;
        bus.req_addr  = 16'h0010;
        bus.req_valid = 1'b1;
        @(negedge clock);
        hi = 0; lo = 0; hi2 = 0;
        while (bus.mem_read_enable && hi < 200) begin hi++; @(negedge clock); end
        while (!bus.mem_read_enable && lo < 200) begin lo++; @(negedge clock); end
        bus.req_valid = 1'b0;
        while (bus.mem_read_enable && hi2 < 200) begin hi2++; @(negedge clock); end
        check("b2b_first_hi", hi, 11);
        check("b2b_gap_low", lo, 4);
        check("b2b_second_hi", hi2, 11);
        check("b2b_rdata", {32'd0, bus.rsp_rdata}, 64'hDEAD_BEEF);
        wait_idle("b2b_idle");

        // Response stall with stray ready pulses and a pending request.
        bus.rsp_ready = 1'b0;
        issue(1'b0, 16'h0010, 32'h0);
        wait_done(1'b0, hi);
        check("stall_en_cycles", hi, 11);
        force_rd      = 1'b1;
        force_wr      = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 16'h0050;
        bus.req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("stall_valid", {63'd0, bus.rsp_valid}, 64'd1);
            check("stall_rdata", {32'd0, bus.rsp_rdata}, 64'hDEAD_BEEF);
            check("stall_req_ready", {63'd0, bus.req_ready}, 64'd0);
            check("stall_en", {62'd0, bus.mem_read_enable, bus.mem_write_enable}, 64'd0);
        end
        bus.rsp_ready = 1'b1;
        force_rd      = 1'b0;
        force_wr      = 1'b0;
        bus.req_valid = 1'b0;
        @(negedge clock);
        check("stall_release", {63'd0, bus.rsp_valid}, 64'd0);
        wait_idle("stall_idle");
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (bus.rsp_valid || bus.mem_read_enable || bus.mem_write_enable) seen++;
        end
        check("stall_no_extra", seen, 0);

        // Reset during BUSY discards the write.
        issue(1'b1, 16'h0030, 32'h1234_5678);
        repeat (3) @(negedge clock);
        check("busy_before_rst", {63'd0, bus.mem_write_enable}, 64'd1);
        reset = 1'b0;
        @(negedge clock);
        check("busy_rst_en", {62'd0, bus.mem_read_enable, bus.mem_write_enable}, 64'd0);
        check("busy_rst_valid", {63'd0, bus.rsp_valid}, 64'd0);
        check("busy_rst_addr", {48'd0, bus.mem_addr}, 64'd0);
        reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clock);
            if (bus.rsp_valid) seen++;
        end
        check("busy_rst_no_rsp", seen, 0);
        issue(1'b0, 16'h0030, 32'h0);
        wait_done(1'b0, hi);
        check("post_rst_hi", hi, 11);
        check("post_rst_rdata", {32'd0, bus.rsp_rdata}, 64'd0);
        wait_idle("post_rst_idle1");
        issue(1'b1, 16'h0030, 32'h1234_5678);
        wait_done(1'b1, hi);
        wait_idle("post_rst_idle2");
        issue(1'b0, 16'h0030, 32'h0);
        wait_done(1'b0, hi);
        check("post_rst_wr_rd", {32'd0, bus.rsp_rdata}, 64'h1234_5678);
        wait_idle("post_rst_idle3");

        // Memory never responds.
        mem_auto = 1'b0;
        issue(1'b0, 16'h0040, 32'h0);
`ifdef MEM_REQ_TIMEOUT_EN
        wait_done(1'b0, hi);
        check("tmo_busy_edges", hi, TMO);
        check("tmo_valid", {63'd0, bus.rsp_valid}, 64'd1);
        check("tmo_error", {63'd0, bus.rsp_error}, 64'd1);
        check("tmo_rdata", {32'd0, bus.rsp_rdata}, 64'd0);
        wait_idle("tmo_idle");
        mem_auto = 1'b1;
        issue(1'b0, 16'h0010, 32'h0);
        wait_done(1'b0, hi);
        check("tmo_after_error", {63'd0, bus.rsp_error}, 64'd0);
        check("tmo_after_rdata", {32'd0, bus.rsp_rdata}, 64'hDEAD_BEEF);
        wait_idle("tmo_after_idle");
`else
        seen = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clock);
            if (bus.rsp_valid || bus.rsp_error) seen++;
        end
        check("notmo_no_rsp", seen, 0);
        check("notmo_still_busy", {63'd0, bus.mem_read_enable}, 64'd1);
        reset = 1'b0;
        @(negedge clock);
        check("notmo_rst_en", {63'd0, bus.mem_read_enable}, 64'd0);
        reset = 1'b1;
        mem_auto = 1'b1;
        @(negedge clock);
`endif

        check("no_overlap", overlap, 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
